// File: rtl/hpi_bus_master_if.sv
// Request/response and status signals between the register side and hpi_bus_master.
// The requester uses the master modport and hpi_bus_master uses the slave modport.
interface hpi_bus_master_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rst_req;
    logic              busy;
    logic              irq_level;
    logic              irq_pulse;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rst_req,
        input  req_ready, rsp_valid, rsp_rdata, busy, irq_level, irq_pulse
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rst_req,
        output req_ready, rsp_valid, rsp_rdata, busy, irq_level, irq_pulse
    );
endinterface

// File: rtl/hpi_bus_master.sv
// Host-port bus master: programmable setup/strobe/hold chip cycles, a chip-reset
// sequencer, and a synchronised OTG interrupt with a rising-edge pulse.
module hpi_bus_master #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int RST_CYC    = 8,
    parameter int INT_SYNC   = 2
) (
    input  logic              Clk,
    input  logic              Reset_N,
    hpi_bus_master_if.slave   bus,
    inout  wire  [DATA_W-1:0] OTG_DATA,
    output logic [ADDR_W-1:0] OTG_ADDR,
    output logic              OTG_RD_N,
    output logic              OTG_WR_N,
    output logic              OTG_CS_N,
    output logic              OTG_RST_N,
    input  logic              OTG_INT
);
    localparam int MAX_TS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_TSH = (MAX_TS > HOLD_CYC) ? MAX_TS : HOLD_CYC;
    localparam int MAX_CYC = (MAX_TSH > RST_CYC) ? MAX_TSH : RST_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {CHIPRST, IDLE, SETUP, STROBE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                cs_n_q, rd_n_q, wr_n_q, rst_n_q, oe_q, rsp_valid_q;
    logic [INT_SYNC-1:0] sync_q;
    logic                irq_pulse_q;
    logic                ready, last_cnt, in_txn_d, sample_rd;

    // Each phase loads its length on entry and leaves when the count reaches one.
    assign last_cnt = (cnt_q <= CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready   = 1'b0;
        if (bus.rst_req && (state_q != IDLE)) pend_d = 1'b1;
        case (state_q)
            CHIPRST: begin
                if (last_cnt) state_d = IDLE;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            IDLE: begin
                ready = !(pend_q || bus.rst_req);
                if (pend_q || bus.rst_req) begin
                    state_d = CHIPRST;
                    cnt_d   = CNT_W'(RST_CYC);
                    pend_d  = 1'b0;
                end else if (bus.req_valid) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC);
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            SETUP: begin
                if (last_cnt) begin
                    state_d = STROBE;
                    cnt_d   = CNT_W'(STROBE_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (last_cnt) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (last_cnt) state_d = IDLE;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = CHIPRST;
                cnt_d   = CNT_W'(RST_CYC);
            end
        endcase
    end

    assign in_txn_d  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    // Read data is captured on the edge that ends the last strobe clock.
    assign sample_rd = (state_q == STROBE) && last_cnt && !wr_q;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q     <= CHIPRST;
            cnt_q       <= CNT_W'(RST_CYC);
            pend_q      <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rst_n_q     <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            sync_q      <= '0;
            irq_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_n_q      <= !in_txn_d;
            rd_n_q      <= !((state_d == STROBE) && !wr_d);
            wr_n_q      <= !((state_d == STROBE) && wr_d);
            rst_n_q     <= (state_d != CHIPRST);
            oe_q        <= in_txn_d && wr_d;
            rsp_valid_q <= (state_q == HOLD) && (state_d == IDLE);
            if (sample_rd) rdata_q <= OTG_DATA;
            sync_q      <= {sync_q[INT_SYNC-2:0], OTG_INT};
            irq_pulse_q <= sync_q[INT_SYNC-2] & ~sync_q[INT_SYNC-1];
        end
    end

    assign OTG_DATA      = oe_q ? wdata_q : {DATA_W{1'bz}};
    assign OTG_ADDR      = addr_q;
    assign OTG_CS_N      = cs_n_q;
    assign OTG_RD_N      = rd_n_q;
    assign OTG_WR_N      = wr_n_q;
    assign OTG_RST_N     = rst_n_q;
    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.irq_level = sync_q[INT_SYNC-1];
    assign bus.irq_pulse = irq_pulse_q;
endmodule

// File: tb/tb_hpi_bus_master.sv
// Bench for hpi_bus_master: an OTG chip model with a register file and a pull-up
// on the data bus, plus a cycle-level reference model of the chip-cycle waveform.
module tb_hpi_bus_master;
    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int S     = 1;
    localparam int T     = 4;
    localparam int H     = 1;
    localparam int RSTC  = 8;
    localparam int L     = S + T + H;
    localparam int NC    = L + 2;

    logic          Clk     = 1'b0;
    logic          Reset_N = 1'b1;
    logic          OTG_INT = 1'b0;
    tri1  [DW-1:0] otg_data;
    logic [AW-1:0] otg_addr;
    logic          otg_rd_n, otg_wr_n, otg_cs_n, otg_rst_n;

    hpi_bus_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    hpi_bus_master #(
        .DATA_W(DW), .ADDR_W(AW), .SETUP_CYC(S), .STROBE_CYC(T),
        .HOLD_CYC(H), .RST_CYC(RSTC), .INT_SYNC(2)
    ) dut (
        .Clk(Clk), .Reset_N(Reset_N), .bus(bus),
        .OTG_DATA(otg_data), .OTG_ADDR(otg_addr), .OTG_RD_N(otg_rd_n),
        .OTG_WR_N(otg_wr_n), .OTG_CS_N(otg_cs_n), .OTG_RST_N(otg_rst_n),
        .OTG_INT(OTG_INT)
    );

    always #5 Clk = ~Clk;

    // Chip model: drives its register while selected and read-strobed, captures writes.
    logic [DW-1:0] chip_mem [4] = '{16'h0F0F, 16'hBEEF, 16'h5A5A, 16'hC3C3};
    assign otg_data = (!otg_cs_n && !otg_rd_n) ? chip_mem[otg_addr] : {DW{1'bz}};
    always @(posedge Clk) if (!otg_cs_n && !otg_wr_n) chip_mem[otg_addr] <= otg_data;

    logic [DW-1:0] ref_mem [4] = '{16'h0F0F, 16'hBEEF, 16'h5A5A, 16'hC3C3};
    logic [DW-1:0] last_rd = '0;

    int checks   = 0;
    int failures = 0;

    logic          s_cs   [0:31];
    logic          s_rd   [0:31];
    logic          s_wr   [0:31];
    logic          s_rspv [0:31];
    logic          s_rdy  [0:31];
    logic [DW-1:0] s_data [0:31];
    logic [AW-1:0] s_addr [0:31];
    logic [DW-1:0] s_rdat [0:31];

    typedef struct packed {
        logic          cs_n;
        logic          rd_n;
        logic          wr_n;
        logic          rspv;
        logic          rdy;
        logic [DW-1:0] data;
    } pins_t;

    // Expected pins in cycle n after acceptance of one isolated transaction.
    function automatic pins_t model_pins(input bit wr, input logic [DW-1:0] wd,
                                         input logic [DW-1:0] rd_val, input int n);
        pins_t p;
        bit in_txn = (n >= 1) && (n <= L);
        bit strobe = (n > S) && (n <= S + T);
        p.cs_n = !in_txn;
        p.rd_n = !(strobe && !wr);
        p.wr_n = !(strobe && wr);
        p.rspv = (n == L + 1);
        p.rdy  = (n > L);
        p.data = (wr && in_txn) ? wd : ((!wr && strobe) ? rd_val : {DW{1'b1}});
        return p;
    endfunction

    task automatic sample_cycle(input int n);
        s_cs[n]   = otg_cs_n;
        s_rd[n]   = otg_rd_n;
        s_wr[n]   = otg_wr_n;
        s_rspv[n] = bus.rsp_valid;
        s_rdy[n]  = bus.req_ready;
        s_data[n] = otg_data;
        s_addr[n] = otg_addr;
        s_rdat[n] = bus.rsp_rdata;
    endtask

    // Presents one request, waits (bounded) for acceptance and records ncyc cycles.
    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int ncyc, output bit ok);
        int guard = 0;
        @(negedge Clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (bus.req_ready !== 1'b1 && guard < 40) begin
            @(negedge Clk);
            guard++;
        end
        ok = (bus.req_ready === 1'b1);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge Clk);
            sample_cycle(n);
            if (n == 1) bus.req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        #1 Reset_N = 1'b0;
        #2;
        for (int pass = 0; pass < 2; pass++) begin
            obs = {otg_rst_n, otg_cs_n, otg_rd_n, otg_wr_n, otg_addr, bus.req_ready,
                   bus.rsp_valid, bus.busy, bus.irq_level, bus.irq_pulse};
            checks++;
            if (obs !== 11'b0_111_00_0_0_1_0_0) begin
                failures++;
                $display("FAIL reset_ctrl pass%0d got=%b exp=%b", pass, obs, 11'b0_111_00_0_0_1_0_0);
            end
            checks++;
            if (bus.rsp_rdata !== 16'h0 || otg_data !== 16'hFFFF) begin
                failures++;
                $display("FAIL reset_data pass%0d rdata=%h bus=%h exp rdata=0 bus=ffff(Z)",
                         pass, bus.rsp_rdata, otg_data);
            end
            repeat (3) @(negedge Clk);
        end
    endtask

    task automatic test_power_on();
        logic [2:0] obs, exp_v;
        @(negedge Clk);
        Reset_N = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            obs   = {otg_rst_n, bus.req_ready, bus.busy};
            exp_v = {k >= RSTC, k >= RSTC, k < RSTC};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL power_on clk%0d rst_n/ready/busy got=%b exp=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_write();
        bit ok;
        logic [20:0] obs, exp_v;
        run_txn(1'b1, 2'b10, 16'h1234, NC, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL write_accept ready=0 exp=1"); end
        for (int n = 1; n <= NC; n++) begin
            exp_v = model_pins(1'b1, 16'h1234, '0, n);
            obs   = {s_cs[n], s_rd[n], s_wr[n], s_rspv[n], s_rdy[n], s_data[n]};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL write_cycle%0d got=%h exp=%h", n, obs, exp_v);
            end
        end
        checks++;
        if (s_addr[1] !== 2'b10 || s_rdat[L+1] !== last_rd) begin
            failures++;
            $display("FAIL write_addr_rdata addr=%b rdata=%h exp addr=10 rdata=%h",
                     s_addr[1], s_rdat[L+1], last_rd);
        end
        ref_mem[2] = 16'h1234;
    endtask

    task automatic test_read();
        bit ok;
        logic [20:0] obs, exp_v;
        run_txn(1'b0, 2'b01, 16'hAAAA, NC, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL read_accept ready=0 exp=1"); end
        for (int n = 1; n <= NC; n++) begin
            exp_v = model_pins(1'b0, '0, 16'hBEEF, n);
            obs   = {s_cs[n], s_rd[n], s_wr[n], s_rspv[n], s_rdy[n], s_data[n]};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL read_cycle%0d got=%h exp=%h", n, obs, exp_v);
            end
        end
        checks++;
        if (s_rdat[L+1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL read_rdata got=%h exp=beef", s_rdat[L+1]);
        end
        last_rd = 16'hBEEF;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d0 = 16'($urandom), d1 = 16'($urandom);
        logic [AW-1:0] a0 = 2'($urandom), a1 = 2'($urandom);
        logic [20:0] obs, exp_v;
        int guard = 0;
        @(negedge Clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a0; bus.req_wdata = d0;
        while (bus.req_ready !== 1'b1 && guard < 40) begin @(negedge Clk); guard++; end
        checks++;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept ready=0 exp=1"); end
        for (int n = 1; n <= 2 * L + 3; n++) begin
            @(negedge Clk);
            sample_cycle(n);
            if (n == 1) begin bus.req_addr = a1; bus.req_wdata = d1; end
            if (n == L + 2) bus.req_valid = 1'b0;
        end
        for (int n = 1; n <= 2 * L + 3; n++) begin
            exp_v = (n <= L + 1) ? model_pins(1'b1, d0, '0, n) : model_pins(1'b1, d1, '0, n - L - 1);
            obs   = {s_cs[n], s_rd[n], s_wr[n], s_rspv[n], s_rdy[n], s_data[n]};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL b2b_cycle%0d got=%h exp=%h", n, obs, exp_v);
            end
        end
        checks++;
        if (s_addr[1] !== a0 || s_addr[L+2] !== a1) begin
            failures++;
            $display("FAIL b2b_addr got=%b,%b exp=%b,%b", s_addr[1], s_addr[L+2], a0, a1);
        end
        ref_mem[a0] = d0;
        ref_mem[a1] = d1;
    endtask

    task automatic test_rst_req();
        logic [DW-1:0] d = 16'($urandom);
        logic [AW-1:0] a = 2'($urandom);
        logic [4:0] obs, exp_v;
        int guard = 0;
        @(negedge Clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_wdata = d;
        while (bus.req_ready !== 1'b1 && guard < 40) begin @(negedge Clk); guard++; end
        checks++;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rstreq_accept ready=0 exp=1"); end
        for (int n = 1; n <= L + RSTC + 3; n++) begin
            @(negedge Clk);
            obs   = {otg_cs_n, otg_wr_n, bus.rsp_valid, otg_rst_n, bus.req_ready};
            exp_v = {n > L, !(n > S && n <= S + T), n == L + 1,
                     !(n >= L + 2 && n <= L + 1 + RSTC), n >= L + 2 + RSTC};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL rstreq_cycle%0d cs/wr/rspv/rst_n/ready got=%b exp=%b", n, obs, exp_v);
            end
            if (n == S + 1) bus.rst_req = 1'b1;
            if (n == S + 2) bus.rst_req = 1'b0;
            if (n == L + 2 + RSTC) bus.req_valid = 1'b0;
        end
        ref_mem[a] = d;
    endtask

    task automatic test_random();
        bit ok, addr_ok;
        logic [20:0] obs, exp_v;
        for (int i = 0; i < 24; i++) begin
            bit            wr = 1'($urandom);
            logic [AW-1:0] a  = 2'($urandom);
            logic [DW-1:0] d  = 16'($urandom);
            logic [DW-1:0] rv = ref_mem[a];
            run_txn(wr, a, d, NC, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand%0d_accept ready=0 exp=1", i); end
            addr_ok = 1'b1;
            for (int n = 1; n <= NC; n++) begin
                exp_v = model_pins(wr, d, rv, n);
                obs   = {s_cs[n], s_rd[n], s_wr[n], s_rspv[n], s_rdy[n], s_data[n]};
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL rand%0d_cycle%0d wr=%0d got=%h exp=%h", i, n, wr, obs, exp_v);
                end
                if (n <= L && s_addr[n] !== a) addr_ok = 1'b0;
            end
            if (wr) ref_mem[a] = d;
            else    last_rd = rv;
            checks++;
            if (!addr_ok || s_rdat[L+1] !== last_rd) begin
                failures++;
                $display("FAIL rand%0d_addr_rdata addr_ok=%0d rdata=%h exp rdata=%h",
                         i, addr_ok, s_rdat[L+1], last_rd);
            end
        end
    endtask

    task automatic test_irq();
        int off = $urandom_range(1, 4);
        logic [1:0] obs, exp_v;
        @(posedge Clk);
        #(off) OTG_INT = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge Clk);
            obs   = {bus.irq_level, bus.irq_pulse};
            exp_v = {k >= 2, k == 2};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL irq_rise k%0d level/pulse got=%b exp=%b", k, obs, exp_v);
            end
        end
        OTG_INT = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            obs   = {bus.irq_level, bus.irq_pulse};
            exp_v = {k < 2, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL irq_fall k%0d level/pulse got=%b exp=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        int k = 0;
        logic [6:0] obs;
        @(negedge Clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 2'($urandom);
        while (bus.req_ready !== 1'b1 && guard < 40) begin @(negedge Clk); guard++; end
        repeat (S + 2) begin
            @(negedge Clk);
            bus.req_valid = 1'b0;
        end
        checks++;
        if (otg_rd_n !== 1'b0) begin failures++; $display("FAIL arst_pre rd_n got=%b exp=0", otg_rd_n); end
        #2 Reset_N = 1'b0;
        #1;
        obs = {otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n, bus.req_ready, bus.busy, bus.rsp_valid};
        checks++;
        if (obs !== 7'b1110010) begin
            failures++;
            $display("FAIL arst_pins cs/rd/wr/rst_n/ready/busy/rspv got=%b exp=1110010", obs);
        end
        checks++;
        if (otg_data !== 16'hFFFF || bus.rsp_rdata !== 16'h0) begin
            failures++;
            $display("FAIL arst_bus bus=%h rdata=%h exp bus=ffff(Z) rdata=0", otg_data, bus.rsp_rdata);
        end
        last_rd = '0;
        @(negedge Clk);
        Reset_N = 1'b1;
        while (bus.req_ready !== 1'b1 && k < 20) begin @(negedge Clk); k++; end
        checks++;
        if (k != RSTC) begin
            failures++;
            $display("FAIL arst_recover ready after %0d clocks exp %0d", k, RSTC);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rst_req   = 1'b0;
        test_reset();
        test_power_on();
        test_write();
        test_read();
        test_back_to_back();
        test_rst_req();
        test_random();
        test_irq();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
